// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with result broadcast capture and in-order single-entry commit
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 flushIn,
    input  logic                 issueValid,
    input  logic                 issueHasDest,
    input  logic [REG_WIDTH-1:0] issueDest,
    input  logic                 issueReady,
    input  logic [31:0]          issueVal,
    output logic [ROB_WIDTH-1:0] issueRobIndex,
    output logic                 full,
    output logic                 empty,
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsUpdateVal,
    input  logic                 lsbUpdate,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbUpdateVal,
    input  logic [ROB_WIDTH-1:0] query1Index,
    input  logic [ROB_WIDTH-1:0] query2Index,
    output logic                 query1Ready,
    output logic                 query2Ready,
    output logic [31:0]          query1Val,
    output logic [31:0]          query2Val,
    output logic                 commitValid,
    output logic [ROB_WIDTH-1:0] commitRobIndex,
    output logic                 commitHasDest,
    output logic [REG_WIDTH-1:0] commitDest,
    output logic [31:0]          commitVal
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] CNT_MAX  = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [ROB_WIDTH:0] CNT_FULL = {1'b0, {ROB_WIDTH{1'b1}}};

    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     ready_q;
    logic [31:0]          value_q    [DEPTH];
    logic [DEPTH-1:0]     has_dest_q;
    logic [REG_WIDTH-1:0] dest_q     [DEPTH];

    logic do_issue;
    logic do_commit;

    assign do_issue      = issueValid && (count_q < CNT_MAX);
    assign do_commit     = valid_q[head_q] && ready_q[head_q];
    assign issueRobIndex = tail_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q >= CNT_FULL);

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flushIn) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_commit) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (do_issue) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + 1'b1;
            end
            case ({do_issue, do_commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset; lsb written last so it wins a same-index collision.
    always_ff @(posedge clockIn) begin
        if (!flushIn) begin
            if (do_issue) begin
                ready_q[tail_q]    <= issueReady;
                value_q[tail_q]    <= issueVal;
                has_dest_q[tail_q] <= issueHasDest;
                dest_q[tail_q]     <= issueDest;
            end
            if (rsUpdate && valid_q[rsRobIndex]) begin
                ready_q[rsRobIndex] <= 1'b1;
                value_q[rsRobIndex] <= rsUpdateVal;
            end
            if (lsbUpdate && valid_q[lsbRobIndex]) begin
                ready_q[lsbRobIndex] <= 1'b1;
                value_q[lsbRobIndex] <= lsbUpdateVal;
            end
        end
    end

    function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] idx);
        if (valid_q[idx] && ready_q[idx]) return {1'b1, value_q[idx]};
        if (lsbUpdate && (lsbRobIndex == idx)) return {1'b1, lsbUpdateVal};
        if (rsUpdate && (rsRobIndex == idx)) return {1'b1, rsUpdateVal};
        return 33'd0;
    endfunction

    always_comb begin
        {query1Ready, query1Val} = lookup(query1Index);
        {query2Ready, query2Val} = lookup(query2Index);
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            commitValid    <= 1'b0;
            commitRobIndex <= '0;
            commitHasDest  <= 1'b0;
            commitDest     <= '0;
            commitVal      <= '0;
        end else if (flushIn) begin
            commitValid <= 1'b0;
        end else begin
            commitValid <= do_commit;
            if (do_commit) begin
                commitRobIndex <= head_q;
                commitHasDest  <= has_dest_q[head_q];
                commitDest     <= dest_q[head_q];
                commitVal      <= value_q[head_q];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clockIn = 1'b0;
    logic        resetIn, flushIn;
    logic        issueValid, issueHasDest, issueReady;
    logic [4:0]  issueDest;
    logic [31:0] issueVal;
    logic [3:0]  issueRobIndex;
    logic        full, empty;
    logic        rsUpdate, lsbUpdate;
    logic [3:0]  rsRobIndex, lsbRobIndex, query1Index, query2Index;
    logic [31:0] rsUpdateVal, lsbUpdateVal, query1Val, query2Val;
    logic        query1Ready, query2Ready;
    logic        commitValid, commitHasDest;
    logic [3:0]  commitRobIndex;
    logic [4:0]  commitDest;
    logic [31:0] commitVal;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(5)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .flushIn(flushIn),
        .issueValid(issueValid), .issueHasDest(issueHasDest), .issueDest(issueDest),
        .issueReady(issueReady), .issueVal(issueVal), .issueRobIndex(issueRobIndex),
        .full(full), .empty(empty),
        .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsUpdateVal(rsUpdateVal),
        .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal),
        .query1Index(query1Index), .query2Index(query2Index),
        .query1Ready(query1Ready), .query2Ready(query2Ready),
        .query1Val(query1Val), .query2Val(query2Val),
        .commitValid(commitValid), .commitRobIndex(commitRobIndex),
        .commitHasDest(commitHasDest), .commitDest(commitDest), .commitVal(commitVal)
    );

    always #5 clockIn = ~clockIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clockIn);
        #2;
    endtask

    task automatic issue(input logic [4:0] dest, input logic rdy, input logic [31:0] val);
        issueValid   = 1'b1;
        issueHasDest = 1'b1;
        issueDest    = dest;
        issueReady   = rdy;
        issueVal     = val;
    endtask

    initial begin
        resetIn = 1'b0; flushIn = 1'b0;
        issueValid = 1'b0; issueHasDest = 1'b0; issueDest = '0; issueReady = 1'b0; issueVal = '0;
        rsUpdate = 1'b0; rsRobIndex = '0; rsUpdateVal = '0;
        lsbUpdate = 1'b0; lsbRobIndex = '0; lsbUpdateVal = '0;
        query1Index = '0; query2Index = '0;
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_idx", issueRobIndex, 0);
        chk("rst_cv", commitValid, 0);
        resetIn = 1'b1;

        // single entry, late rs result
        issue(5'd5, 1'b0, 32'h0);
        step(); issueValid = 1'b0; #1;
        chk("s1_idx", issueRobIndex, 1);
        chk("s1_empty", empty, 0);
        step();
        rsUpdate = 1'b1; rsRobIndex = 4'd0; rsUpdateVal = 32'h1234; query1Index = 4'd0; #1;
        chk("s1_q_bcast_rdy", query1Ready, 1);
        chk("s1_q_bcast_val", query1Val, 32'h1234);
        step(); rsUpdate = 1'b0; #1;
        chk("s1_cv_early", commitValid, 0);
        chk("s1_q_stored", query1Val, 32'h1234);
        step(); #1;
        chk("s1_cv", commitValid, 1);
        chk("s1_cdest", commitDest, 5);
        chk("s1_cval", commitVal, 32'h1234);
        chk("s1_cidx", commitRobIndex, 0);
        chk("s1_chas", commitHasDest, 1);
        chk("s1_empty_after", empty, 1);
        step(); #1;
        chk("s1_cv_drop", commitValid, 0);

        // fill to capacity
        flushIn = 1'b1; step(); flushIn = 1'b0; #1;
        chk("f_idx0", issueRobIndex, 0);
        chk("f_empty", empty, 1);
        for (int i = 0; i < 14; i++) begin
            issue(5'(i), 1'b0, 32'(i));
            step();
        end
        issueValid = 1'b0; #1;
        chk("f14_full", full, 0);
        chk("f14_cnt", dut.count_q, 14);
        issue(5'd14, 1'b0, 32'h0); step(); issueValid = 1'b0;
        query1Index = 4'd5; #1;
        chk("f15_full", full, 1);
        chk("f15_idx", issueRobIndex, 15);
        chk("f15_cnt", dut.count_q, 15);
        chk("f_q_unready", query1Ready, 0);
        chk("f_q_unready_val", query1Val, 0);
        issue(5'd15, 1'b0, 32'h0); step(); issueValid = 1'b0; #1;
        chk("f16_idx", issueRobIndex, 0);
        chk("f16_cnt", dut.count_q, 16);
        chk("f16_full", full, 1);
        issue(5'd16, 1'b0, 32'h0); step(); issueValid = 1'b0; #1;
        chk("f17_idx", issueRobIndex, 0);
        chk("f17_cnt", dut.count_q, 16);
        chk("f17_empty", empty, 0);
        chk("f17_cv", commitValid, 0);
        flushIn = 1'b1; step(); flushIn = 1'b0;

        // out-of-order completion, in-order commit
        issue(5'd1, 1'b0, 32'h0); step();
        issue(5'd2, 1'b0, 32'h0); step();
        issue(5'd3, 1'b0, 32'h0); step();
        issueValid = 1'b0;
        rsUpdate = 1'b1; rsRobIndex = 4'd2; rsUpdateVal = 32'h22; step(); rsUpdate = 1'b0;
        lsbUpdate = 1'b1; lsbRobIndex = 4'd1; lsbUpdateVal = 32'h11; step(); lsbUpdate = 1'b0; #1;
        chk("o_cv_wait", commitValid, 0);
        rsUpdate = 1'b1; rsRobIndex = 4'd0; rsUpdateVal = 32'h10; step(); rsUpdate = 1'b0; #1;
        chk("o_cv_lat", commitValid, 0);
        step(); #1;
        chk("o_c0_idx", commitRobIndex, 0);
        chk("o_c0_val", commitVal, 32'h10);
        step(); #1;
        chk("o_c1_cv", commitValid, 1);
        chk("o_c1_idx", commitRobIndex, 1);
        chk("o_c1_val", commitVal, 32'h11);
        step(); #1;
        chk("o_c2_cv", commitValid, 1);
        chk("o_c2_idx", commitRobIndex, 2);
        chk("o_c2_dest", commitDest, 3);
        chk("o_c2_val", commitVal, 32'h22);
        step(); #1;
        chk("o_cv_end", commitValid, 0);
        chk("o_empty", empty, 1);

        // same-index rs/lsb collision
        chk("c_idx", issueRobIndex, 3);
        issue(5'd7, 1'b0, 32'h0); step(); issueValid = 1'b0;
        rsUpdate = 1'b1; rsRobIndex = 4'd3; rsUpdateVal = 32'hA;
        lsbUpdate = 1'b1; lsbRobIndex = 4'd3; lsbUpdateVal = 32'hB;
        query1Index = 4'd3; query2Index = 4'd3; #1;
        chk("c_q1_rdy", query1Ready, 1);
        chk("c_q1_val", query1Val, 32'hB);
        step(); rsUpdate = 1'b0;
        lsbUpdateVal = 32'hC; #1;
        chk("c_q2_stored_rdy", query2Ready, 1);
        chk("c_q2_stored_val", query2Val, 32'hB);
        chk("c_cv_early", commitValid, 0);
        step(); lsbUpdate = 1'b0; #1;
        chk("c_cv", commitValid, 1);
        chk("c_cidx", commitRobIndex, 3);
        chk("c_cval", commitVal, 32'hB);
        chk("c_cdest", commitDest, 7);

        // ready-at-issue entries, then wrap-around
        issue(5'd4, 1'b1, 32'h44); step(); #1;
        chk("w_cv_lat", commitValid, 0);
        issue(5'd5, 1'b1, 32'h45); step(); #1;
        chk("w_cv_rdy", commitValid, 1);
        chk("w_cidx_rdy", commitRobIndex, 4);
        chk("w_cval_rdy", commitVal, 32'h44);
        for (int i = 6; i < 14; i++) begin
            issue(5'(i), 1'b1, 32'(i));
            step();
        end
        issueValid = 1'b0;
        step(); step(); step(); #1;
        chk("w_empty", empty, 1);
        chk("w_idx14", issueRobIndex, 14);
        chk("w_head14", dut.head_q, 14);
        issue(5'd14, 1'b0, 32'h0); step();
        issue(5'd15, 1'b0, 32'h0); step();
        issue(5'd16, 1'b0, 32'h0); step();
        issueValid = 1'b0; #1;
        chk("w_tail1", issueRobIndex, 1);
        chk("w_cnt3", dut.count_q, 3);
        rsUpdate = 1'b1; rsRobIndex = 4'd0;  rsUpdateVal = 32'hC0; step();
        rsRobIndex = 4'd15; rsUpdateVal = 32'hCF; step();
        rsRobIndex = 4'd14; rsUpdateVal = 32'hCE; step();
        rsUpdate = 1'b0; #1;
        chk("w_cv_wait", commitValid, 0);
        step(); #1;
        chk("w_c14_idx", commitRobIndex, 14);
        chk("w_c14_val", commitVal, 32'hCE);
        step(); #1;
        chk("w_c15_idx", commitRobIndex, 15);
        chk("w_c15_val", commitVal, 32'hCF);
        step(); #1;
        chk("w_c0_cv", commitValid, 1);
        chk("w_c0_idx", commitRobIndex, 0);
        chk("w_c0_val", commitVal, 32'hC0);
        chk("w_head1", dut.head_q, 1);
        chk("w_empty_end", empty, 1);

        // flush with pending entries and a colliding issue
        for (int i = 0; i < 5; i++) begin
            issue(5'(i + 1), 1'b0, 32'h0);
            step();
        end
        issueValid = 1'b0; #1;
        chk("x_cnt5", dut.count_q, 5);
        chk("x_idx6", issueRobIndex, 6);
        rsUpdate = 1'b1; rsRobIndex = 4'd1; rsUpdateVal = 32'h77; step(); rsUpdate = 1'b0;
        flushIn = 1'b1; issue(5'd9, 1'b1, 32'h99); step();
        flushIn = 1'b0; issueValid = 1'b0; #1;
        chk("x_empty", empty, 1);
        chk("x_cnt0", dut.count_q, 0);
        chk("x_idx0", issueRobIndex, 0);
        chk("x_cv", commitValid, 0);
        chk("x_full", full, 0);
        step(); #1;
        chk("x_cv_next", commitValid, 0);

        // asynchronous reset mid-stream
        issue(5'd2, 1'b1, 32'h55); step();
        issue(5'd3, 1'b1, 32'h66); step();
        issueValid = 1'b0; #1;
        chk("r_cv_pre", commitValid, 1);
        chk("r_cval_pre", commitVal, 32'h55);
        resetIn = 1'b0; #1;
        chk("r_cv", commitValid, 0);
        chk("r_cval", commitVal, 0);
        chk("r_cdest", commitDest, 0);
        chk("r_empty", empty, 1);
        chk("r_idx", issueRobIndex, 0);
        step(); resetIn = 1'b1;
        step(); #1;
        chk("r_resume_empty", empty, 1);
        chk("r_resume_cv", commitValid, 0);
        issue(5'd1, 1'b0, 32'h0); step(); issueValid = 1'b0; #1;
        chk("r_resume_idx", issueRobIndex, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: ReorderBuffer

Interface
REQ-001 SHALL take parameter ROB_WIDTH, default 4, log2 of entry count (16 entries).
REQ-002 SHALL take parameter REG_WIDTH, default 5, architectural register index width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide ports as follows:
- clockIn  in  1  clock, rising edge.
- resetIn  in  1  asynchronous active-low reset.
- flushIn  in  1  synchronous flush, used for mispredict recovery.
- issueValid  in  1  allocate one entry this cycle.
- issueHasDest  in  1  entry writes a register.
- issueDest  in  REG_WIDTH  destination register.
- issueReady  in  1  value already known at issue.
- issueVal  in  32  value when issueReady=1.
- issueRobIndex  out  ROB_WIDTH  index the next allocation receives (tail).
- full  out  1  no further issue permitted.
- empty  out  1  no valid entries.
- rsUpdate / rsRobIndex / rsUpdateVal  in  1/ROB_WIDTH/32  reservation-station result broadcast.
- lsbUpdate / lsbRobIndex / lsbUpdateVal  in  1/ROB_WIDTH/32  load/store-buffer result broadcast.
- query1Index, query2Index  in  ROB_WIDTH  operand lookup.
- query1Ready, query2Ready  out  1  value available.
- query1Val, query2Val  out  32  looked-up value.
- commitValid  out  1  one entry retired, registered.
- commitRobIndex  out  ROB_WIDTH  retired index.
- commitHasDest  out  1  retired entry writes a register.
- commitDest  out  REG_WIDTH  retired destination.
- commitVal  out  32  retired value.

Function
REQ-005 SHALL be a circular buffer with head and tail pointers of ROB_WIDTH bits and a count of ROB_WIDTH+1 bits; pointers SHALL wrap from 2**ROB_WIDTH-1 to 0.
REQ-006 SHALL drive issueRobIndex = tail combinationally.
REQ-007 SHALL assert empty when count==0.
REQ-008 SHALL assert full when count >= 2**ROB_WIDTH-1, giving one slot of slack for a registered issuer.
REQ-009 On issueValid with count < 2**ROB_WIDTH, SHALL write the entry at tail with valid=1, ready=issueReady, value=issueVal, hasDest, and dest, and advance tail; when count == 2**ROB_WIDTH, issueValid SHALL be ignored.
REQ-010 On rsUpdate or lsbUpdate naming a valid entry, SHALL set that entry's ready=1 and value to the update value at the edge; updates to invalid entries SHALL be ignored.
REQ-011 When rsUpdate and lsbUpdate name the same index in one cycle, the lsb value SHALL win.
REQ-012 Each edge, if the head entry is valid and ready (registered state, sampled before the edge), SHALL commit it:
- clear its valid bit and advance head;
- drive commitValid=1 with that entry's fields for the following cycle.
Otherwise commitValid SHALL be 0. At most one commit per cycle.
REQ-013 Latency: an update sampled at edge N to the head entry SHALL produce commitValid high in the cycle after edge N+1; an entry issued with issueReady=1 at edge N at an empty head SHALL commit likewise.
REQ-014 Issue and commit in the same cycle SHALL leave count unchanged; count SHALL be incremented on issue and decremented on commit, each independently.
REQ-015 queryNReady SHALL be combinational, with this priority (value taken from the first matching source):
- entry valid and ready: stored value;
- lsbUpdate matching queryNIndex: lsbUpdateVal;
- rsUpdate matching queryNIndex: rsUpdateVal;
- otherwise queryNReady=0 and queryNVal=0.
REQ-016 flushIn SHALL take priority over issue, update and commit at that edge:
- clear all valid bits;
- set head=tail=count=0;
- set commitValid=0 for the next cycle;
- discard any issue in the flush cycle.
REQ-017 Entry storage other than valid bits need not be reset.

Reset
REQ-018 While resetIn=0, SHALL asynchronously force head=tail=count=0, all valid=0, and all commit outputs 0, giving full=0, empty=1, issueRobIndex=0.
REQ-019 Deassertion of reset mid-operation SHALL resume from the empty state; no prior entry survives.

Verification
REQ-020 Reset, then issue dest=x5, issueReady=0; at edge 3, rsUpdate idx 0 val 0x1234 -> commitValid=1, commitDest=5, commitVal=0x1234 in the cycle after edge 4; empty=1 afterwards.
REQ-021 Issue 15 entries with no updates -> full=1 at count 15, issueRobIndex=15; a 16th issue is accepted, a 17th is ignored, and count stays 16.
REQ-022 Issue idx 0, 1, 2; update idx 2 then idx 1 then idx 0 -> commits occur in order 0, 1, 2 on consecutive cycles after idx 0 becomes ready.
REQ-023 Same-cycle rsUpdate and lsbUpdate on idx 3 with values 0xA and 0xB -> query and commit show 0xB; query1Index=3 during that cycle -> query1Ready=1, query1Val=0xB.
REQ-024 Fill to wrap: head=14, tail wraps to 1; entries 14, 15, 0 commit in order and head reaches 1.
REQ-025 With 5 entries pending, assert flushIn together with issueValid -> next cycle empty=1, count=0, issueRobIndex=0, commitValid=0; drive resetIn=0 mid-stream -> outputs cleared immediately, without waiting for a clock edge.
